// File: rtl/ddr_pkt_pkg.sv
// Shared constants, FSM encoding and descriptor type
// for the DDR packet writer.
package ddr_pkt_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int C_4K_BOUNDARY = 4096;
  localparam int C_WORD_BYTES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_AW,
    ST_W,
    ST_B,
    ST_CPL
  } state_t;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  strb;
  } desc_t;

endpackage

// File: rtl/ddr_pkt_writer_if.sv
// AXIS ingress, local-queue request/completion and
// AXI4 write-channel bundle for the DDR packet writer.
interface ddr_pkt_writer_if #(
  parameter int AW = 32
);
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;

  logic          o_wr_ddr_valid;
  logic [15:0]   o_wr_ddr_len;
  logic [AW-1:0] i_wr_ddr_addr;
  logic          i_wr_ddr_ready;

  logic          o_wr_ddr_cpl_valid;
  logic          i_wr_ddr_cpl_ready;
  logic [15:0]   o_wr_ddr_cpl_len;
  logic [AW-1:0] o_wr_ddr_cpl_addr;
  logic [7:0]    o_wr_ddr_cpl_strb;

  logic [3:0]    m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready;

  logic [63:0]   m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;

  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tkeep,
    input  s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output o_wr_ddr_valid, o_wr_ddr_len,
    input  i_wr_ddr_addr, i_wr_ddr_ready,
    output o_wr_ddr_cpl_valid,
    input  i_wr_ddr_cpl_ready,
    output o_wr_ddr_cpl_len,
    output o_wr_ddr_cpl_addr,
    output o_wr_ddr_cpl_strb,
    output m_axi_awid, m_axi_awaddr,
    output m_axi_awlen, m_axi_awsize,
    output m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb,
    output m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tkeep,
    output s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  o_wr_ddr_valid, o_wr_ddr_len,
    output i_wr_ddr_addr, i_wr_ddr_ready,
    input  o_wr_ddr_cpl_valid,
    output i_wr_ddr_cpl_ready,
    input  o_wr_ddr_cpl_len,
    input  o_wr_ddr_cpl_addr,
    input  o_wr_ddr_cpl_strb,
    input  m_axi_awid, m_axi_awaddr,
    input  m_axi_awlen, m_axi_awsize,
    input  m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb,
    input  m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/ddr_pkt_ingress_buf.sv
// AXIS packet ingress: word counting, oversize truncation,
// data FIFO and per-packet descriptor FIFO.
module ddr_pkt_ingress_buf
  import ddr_pkt_pkg::*;
#(
  parameter int P_DATA_FIFO_DEPTH = 512,
  parameter int P_LEN_FIFO_DEPTH  = 16,
  parameter int P_MAX_PKT_WORDS   = 190
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic        tlast,
  input  logic        tvalid,
  output logic        tready,
  output logic        desc_valid,
  output logic [15:0] desc_len,
  output logic [7:0]  desc_strb,
  input  logic        desc_pop,
  output logic        data_valid,
  output logic [63:0] data,
  input  logic        data_pop,
  output logic        err_oversize
);

  localparam int DAW = $clog2(P_DATA_FIFO_DEPTH);
  localparam int LAW = $clog2(P_LEN_FIFO_DEPTH);
  localparam logic [15:0] MAXW = 16'(P_MAX_PKT_WORDS);

  logic [63:0]  dmem [P_DATA_FIFO_DEPTH];
  desc_t        lmem [P_LEN_FIFO_DEPTH];
  logic [DAW:0] dwp, drp;
  logic [LAW:0] lwp, lrp;
  logic [15:0]  cnt;
  logic         data_full, desc_full;
  logic         acc, keep, over, push;
  desc_t        new_desc, head;

  assign data_full = (dwp[DAW] != drp[DAW]) &&
                     (dwp[DAW-1:0] == drp[DAW-1:0]);
  assign desc_full = (lwp[LAW] != lrp[LAW]) &&
                     (lwp[LAW-1:0] == lrp[LAW-1:0]);
  assign tready = !data_full && !desc_full;

  assign acc  = tvalid && tready;
  assign over = (cnt >= MAXW);
  assign keep = acc && !over;
  assign push = acc && tlast;

  // Once the counter saturates the packet is already at max length.
  assign new_desc.len  = over ? MAXW : cnt + 16'd1;
  assign new_desc.strb = over ? 8'hFF : tkeep;

  assign data_valid = (dwp != drp);
  assign data       = dmem[drp[DAW-1:0]];
  assign desc_valid = (lwp != lrp);
  assign head       = lmem[lrp[LAW-1:0]];
  assign desc_len   = head.len;
  assign desc_strb  = head.strb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dwp          <= '0;
      drp          <= '0;
      lwp          <= '0;
      lrp          <= '0;
      cnt          <= '0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= push && over;
      if (keep)     dwp <= dwp + 1'b1;
      if (data_pop) drp <= drp + 1'b1;
      if (push)     lwp <= lwp + 1'b1;
      if (desc_pop) lrp <= lrp + 1'b1;
      if (acc)
        cnt <= tlast ? '0 : (over ? cnt : cnt + 16'd1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (keep) dmem[dwp[DAW-1:0]] <= tdata;
    if (push) lmem[lwp[LAW-1:0]] <= new_desc;
  end

endmodule

// File: rtl/ddr_pkt_writer.sv
// Packet-to-DDR writer: requests an address, writes the packet as
// one or two 4 KB-safe INCR bursts, then posts a completion.
module ddr_pkt_writer
  import ddr_pkt_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DATA_FIFO_DEPTH  = 512,
  parameter int P_LEN_FIFO_DEPTH   = 16,
  parameter int P_MAX_PKT_WORDS    = 190,
  parameter int P_AXI_ID           = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ddr_pkt_writer_if.master bus,
  output logic             o_err_oversize,
  output logic             o_err_bresp
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int WSH = $clog2(C_WORD_BYTES);

  state_t        state;
  logic          req_valid;
  logic [15:0]   len;
  logic [7:0]    strb;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] aw_addr;
  logic [7:0]    aw_len;
  logic [3:0]    aw_id;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic          aw_valid;
  logic          b_ready;
  logic          cpl_valid;
  logic [15:0]   b1, rem;
  logic [7:0]    beat_cnt;

  logic          desc_valid, data_valid;
  logic [15:0]   desc_len;
  logic [7:0]    desc_strb;
  logic [63:0]   data;
  logic          desc_pop;
  logic          w_valid, w_last, w_fire;
  logic [12:0]   room;
  logic [15:0]   split_b1;

  ddr_pkt_ingress_buf #(
    .P_DATA_FIFO_DEPTH (P_DATA_FIFO_DEPTH),
    .P_LEN_FIFO_DEPTH  (P_LEN_FIFO_DEPTH),
    .P_MAX_PKT_WORDS   (P_MAX_PKT_WORDS)
  ) u_ingress (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .tdata        (bus.s_axis_tdata),
    .tkeep        (bus.s_axis_tkeep),
    .tlast        (bus.s_axis_tlast),
    .tvalid       (bus.s_axis_tvalid),
    .tready       (bus.s_axis_tready),
    .desc_valid   (desc_valid),
    .desc_len     (desc_len),
    .desc_strb    (desc_strb),
    .desc_pop     (desc_pop),
    .data_valid   (data_valid),
    .data         (data),
    .data_pop     (w_fire),
    .err_oversize (o_err_oversize)
  );

  // Words left before the next 4 KB boundary.
  assign room = (13'(C_4K_BOUNDARY) -
                 {1'b0, bus.i_wr_ddr_addr[11:0]}) >> WSH;
  assign split_b1 = (len < {3'b0, room}) ? len : {3'b0, room};

  assign desc_pop = (state == ST_IDLE) && desc_valid;
  assign w_valid  = (state == ST_W) && data_valid;
  assign w_last   = w_valid && (beat_cnt == aw_len);
  assign w_fire   = w_valid && bus.m_axi_wready;

  assign bus.m_axi_wvalid = w_valid;
  assign bus.m_axi_wlast  = w_last;
  assign bus.m_axi_wdata  = w_valid ? data : '0;
  assign bus.m_axi_wstrb  = !w_valid ? 8'h00 :
                            (w_last && rem == '0) ? strb : 8'hFF;

  assign bus.m_axi_awid    = aw_id;
  assign bus.m_axi_awaddr  = aw_addr;
  assign bus.m_axi_awlen   = aw_len;
  assign bus.m_axi_awsize  = aw_size;
  assign bus.m_axi_awburst = aw_burst;
  assign bus.m_axi_awvalid = aw_valid;
  assign bus.m_axi_bready  = b_ready;

  assign bus.o_wr_ddr_valid     = req_valid;
  assign bus.o_wr_ddr_len       = len;
  assign bus.o_wr_ddr_cpl_valid = cpl_valid;
  assign bus.o_wr_ddr_cpl_len   = len;
  assign bus.o_wr_ddr_cpl_addr  = start_addr;
  assign bus.o_wr_ddr_cpl_strb  = strb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      req_valid   <= 1'b0;
      len         <= '0;
      strb        <= '0;
      start_addr  <= '0;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_id       <= '0;
      aw_size     <= '0;
      aw_burst    <= '0;
      aw_valid    <= 1'b0;
      b_ready     <= 1'b0;
      cpl_valid   <= 1'b0;
      b1          <= '0;
      rem         <= '0;
      beat_cnt    <= '0;
      o_err_bresp <= 1'b0;
    end else begin
      o_err_bresp <= 1'b0;
      unique case (state)
        ST_IDLE: if (desc_valid) begin
          len       <= desc_len;
          strb      <= desc_strb;
          req_valid <= 1'b1;
          state     <= ST_REQ;
        end
        ST_REQ: if (bus.i_wr_ddr_ready) begin
          req_valid  <= 1'b0;
          start_addr <= bus.i_wr_ddr_addr;
          aw_addr    <= bus.i_wr_ddr_addr;
          aw_len     <= 8'(split_b1 - 16'd1);
          b1         <= split_b1;
          rem        <= len - split_b1;
          aw_id      <= 4'(P_AXI_ID);
          aw_size    <= AXI_SIZE_8B;
          aw_burst   <= AXI_BURST_INCR;
          aw_valid   <= 1'b1;
          state      <= ST_AW;
        end
        ST_AW: if (bus.m_axi_awready) begin
          aw_valid <= 1'b0;
          beat_cnt <= '0;
          state    <= ST_W;
        end
        ST_W: if (w_fire) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (w_last) begin
            b_ready <= 1'b1;
            state   <= ST_B;
          end
        end
        ST_B: if (bus.m_axi_bvalid) begin
          b_ready <= 1'b0;
          if (bus.m_axi_bresp != AXI_RESP_OKAY)
            o_err_bresp <= 1'b1;
          if (rem != '0) begin
            aw_addr  <= aw_addr + (AW'(b1) << WSH);
            aw_len   <= 8'(rem - 16'd1);
            rem      <= '0;
            aw_valid <= 1'b1;
            state    <= ST_AW;
          end else begin
            cpl_valid <= 1'b1;
            state     <= ST_CPL;
          end
        end
        ST_CPL: if (bus.i_wr_ddr_cpl_ready) begin
          cpl_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
